// File: rtl/data_ram_responder.sv
// data_ram_responder: wait-state data RAM on the memory-stage port, driving the pipeline stall vector.
// Define DATA_RAM_RANGE_CHECK_EN to flag out-of-range addresses with err and 32'hDEADBEEF.
module data_ram_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [3:0]  we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic [5:0]  stall,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [3:0] we_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0] wdata_q;
  logic oor_in, oor_q, done;
  logic [31:0] mem [0:(1<<ADDR_W)-1];
`ifdef DATA_RAM_RANGE_CHECK_EN
  assign oor_in = |addr[31:ADDR_W+2];
`else
  assign oor_in = 1'b0;
`endif
  assign done = (state == WAIT) && (cnt == 4'd0);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (req ? WAIT : IDLE) :
               state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
  always_comb begin
    ack   = state == RESP;
    err   = ack && oor_q;
    stall = ((state == IDLE && req) || state == WAIT) ? 6'b011111 : 6'b000000;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt     <= 4'd0;
      we_q    <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      oor_q   <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      if (state == IDLE && req) begin
        cnt     <= 4'(WAIT_CYCLES - 1);
        we_q    <= we;
        idx_q   <= addr[ADDR_W+1:2];
        wdata_q <= wdata;
        oor_q   <= oor_in;
      end else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (done && (we_q == 4'd0 || oor_q)) rdata <= oor_q ? 32'hDEADBEEF : mem[idx_q];
    end
  // RAM is not reset; an async reset forces IDLE so a pending write never reaches done.
  always_ff @(posedge clk)
    if (done && !oor_q)
      for (int b = 0; b < 4; b++)
        if (we_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
endmodule
